// File: rtl/axi_pkg.sv
// axi_pkg: AXI4 constants, fetch FSM states and buffer entry type shared by the IFU
package axi_pkg;
  localparam logic [1:0]  BURST_INCR = 2'b01;
  localparam logic [2:0]  SIZE_4B    = 3'b010;
  localparam logic [1:0]  RESP_OKAY  = 2'b00;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE, AR, R, DROP} ifu_state_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: synchronous FIFO of {pc, inst} entries with push/pop/flush; flush beats push
module ifu_fifo
  import axi_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             din,
  output fetch_entry_t             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty   = count == '0;
  assign full    = count == (AW+1)'(DEPTH);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];
  // pointer and occupancy tracking; a full FIFO still accepts a push when it pops the same cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  // entry storage needs no reset; occupancy alone decides what is valid
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wr_ptr] <= din;
endmodule

// File: rtl/ifu.sv
// ifu: RV32I instruction fetch over single-beat AXI4 reads; optional perf counters via IFU_PERF_CNT_EN
module ifu
  import axi_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2,
  parameter logic [3:0]  AXI_ID    = 4'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_pc,
  output logic [31:0] o_inst,
  output logic        o_valid_inst,
  output logic [3:0]  o_arid,
  output logic [31:0] o_araddr,
  output logic [3:0]  o_arlen,
  output logic [2:0]  o_arsize,
  output logic [1:0]  o_arburst,
  output logic        o_arvalid,
  input  logic        i_arready,
  input  logic [3:0]  i_rid,
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_rresp,
  input  logic        i_rlast,
  input  logic        i_rvalid,
  output logic        o_rready,
  output logic [31:0] o_fetch_cnt,
  output logic [31:0] o_flush_cnt
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  ifu_state_e   state, state_n;
  logic [31:0]  fetch_pc, pc_next;
  logic         redir_pend, ar_hs, beat, push, pop, room, full, empty;
  logic [CW-1:0] count;
  fetch_entry_t head, din;
  assign o_arlen   = '0;
  assign o_arsize  = o_arvalid ? SIZE_4B : '0;
  assign o_arburst = o_arvalid ? BURST_INCR : '0;
  assign o_arid    = o_arvalid ? AXI_ID : '0;
  assign ar_hs        = o_arvalid & i_arready;
  assign beat         = i_rvalid & i_rlast & (i_rid == AXI_ID);
  assign push         = (state == R) & beat & ~i_redirect;
  assign o_valid_inst = ~empty & ~i_redirect;
  assign pop          = o_valid_inst & ~i_stall;
  assign o_pc         = empty ? '0 : head.pc;
  assign o_inst       = empty ? '0 : head.inst;
  assign room         = (count - CW'(pop)) < CW'(BUF_DEPTH - 1);
  assign din          = '{pc: fetch_pc, inst: (i_rresp == RESP_OKAY) ? i_rdata : NOP_INST};
  assign pc_next      = i_redirect ? (i_redirect_pc & ~32'h3) : push ? fetch_pc + 32'd4 : fetch_pc;
  ifu_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (i_redirect),
    .din   (din),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  // next fetch state; a beat that meets a redirect in R is dropped on the spot, so go straight to IDLE
  always_comb
    state_n = (state == IDLE) ? (full ? IDLE : AR)
            : (state == AR)   ? (ar_hs ? ((redir_pend | i_redirect) ? DROP : R) : AR)
            : (state == R)    ? (beat ? ((i_redirect | ~room) ? IDLE : AR) : (i_redirect ? DROP : R))
            :                   (beat ? IDLE : DROP);
  // fetch FSM with registered AXI handshake outputs; araddr latches only when a new request starts
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      redir_pend <= 1'b0;
      o_arvalid  <= 1'b0;
      o_araddr   <= '0;
      o_rready   <= 1'b0;
    end else begin
      state      <= state_n;
      fetch_pc   <= pc_next;
      redir_pend <= (state == AR) & ~ar_hs & (redir_pend | i_redirect);
      o_arvalid  <= state_n == AR;
      o_rready   <= (state_n == R) | (state_n == DROP);
      if (state_n == AR && state != AR) o_araddr <= pc_next;
    end
`ifdef IFU_PERF_CNT_EN
  // delivered-instruction and redirect counters, free-running with wrap
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      o_fetch_cnt <= '0;
      o_flush_cnt <= '0;
    end else begin
      if (pop) o_fetch_cnt <= o_fetch_cnt + 32'd1;
      if (i_redirect) o_flush_cnt <= o_flush_cnt + 32'd1;
    end
`else
  assign o_fetch_cnt = '0;
  assign o_flush_cnt = '0;
`endif
endmodule

// File: tb/tb_ifu.sv
// tb_ifu: self-checking bench for ifu with an AXI slave model and an instruction-stream reference
module tb_ifu;
  import axi_pkg::*;
  logic clk = 1'b0, rst = 1'b0;
  logic i_stall, i_redirect, i_arready, i_rlast, i_rvalid;
  logic [31:0] i_redirect_pc, i_rdata;
  logic [3:0] i_rid;
  logic [1:0] i_rresp;
  logic [31:0] o_pc, o_inst, o_araddr, o_fetch_cnt, o_flush_cnt;
  logic o_valid_inst, o_arvalid, o_rready;
  logic [3:0] o_arid, o_arlen;
  logic [2:0] o_arsize;
  logic [1:0] o_arburst;

  always #5 clk = ~clk;

  ifu dut (
    .clk(clk), .rst(rst), .i_stall(i_stall), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_pc(o_pc), .o_inst(o_inst), .o_valid_inst(o_valid_inst),
    .o_arid(o_arid), .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize),
    .o_arburst(o_arburst), .o_arvalid(o_arvalid), .i_arready(i_arready),
    .i_rid(i_rid), .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast), .i_rvalid(i_rvalid),
    .o_rready(o_rready), .o_fetch_cnt(o_fetch_cnt), .o_flush_cnt(o_flush_cnt)
  );

  int n_cmp = 0, n_bad = 0;
  int err_mode, ar_wait, r_wait, r_cnt, ar_cnt, pops, redirs, cyc, first_valid;
  bit rand_lat, pend, hs_ar, hs_r, prev_ar_stall;
  logic [31:0] paddr, prev_araddr, exp_pc;
  logic [31:0] ar_log[$], pc_log[$], inst_log[$];

  typedef struct {
    int          em;
    int          idx;
    logic [31:0] pc;
    logic [31:0] inst;
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic bit is_err(input logic [31:0] a);
    return err_mode == 1 ? a == 32'h8 : err_mode == 2 ? a[5:2] == 4'hB : 1'b0;
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] a);
    return is_err(a) ? NOP_INST : mem_word(a);
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    return (i >= 0 && i < q.size()) ? q[i] : 32'hDEAD_DEAD;
  endfunction

  task automatic slave_drive();
    i_arready = o_arvalid && ar_cnt >= ar_wait;
    i_rvalid  = pend && r_cnt == 0;
    i_rlast   = i_rvalid;
    i_rid     = 4'h0;
    i_rdata   = i_rvalid ? mem_word(paddr) : '0;
    i_rresp   = (i_rvalid && is_err(paddr)) ? 2'b10 : 2'b00;
  endtask

  task automatic monitor();
    hs_ar = o_arvalid && i_arready;
    hs_r  = i_rvalid && o_rready;
    if (o_arvalid && prev_ar_stall) check("araddr_stable", o_araddr, prev_araddr);
    if (hs_ar) begin
      check("ar_fields", {o_arid, o_arlen, o_arsize, o_arburst, 19'b0}, {4'h0, 4'h0, 3'b010, 2'b01, 19'b0});
      ar_log.push_back(o_araddr);
    end
    prev_ar_stall = o_arvalid && !i_arready;
    prev_araddr   = o_araddr;
    if (i_redirect) begin
      check("valid_during_redirect", 32'(o_valid_inst), 32'd0);
      exp_pc = i_redirect_pc & ~32'h3;
      redirs++;
    end else if (o_valid_inst && !i_stall) begin
      check("pop_pc", o_pc, exp_pc);
      check("pop_inst", o_inst, exp_inst(exp_pc));
      pc_log.push_back(o_pc);
      inst_log.push_back(o_inst);
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    if (o_valid_inst && first_valid < 0) first_valid = cyc;
    cyc++;
  endtask

  task automatic slave_update();
    if (hs_r) pend = 1'b0;
    else if (pend && r_cnt > 0) r_cnt--;
    if (hs_ar) begin
      check("one_outstanding", 32'(pend), 32'd0);
      pend  = 1'b1;
      paddr = ar_log[$];
      r_cnt = rand_lat ? int'($urandom_range(0, 3)) : r_wait;
      if (rand_lat) ar_wait = $urandom_range(0, 3);
      ar_cnt = 0;
    end else ar_cnt = prev_ar_stall ? ar_cnt + 1 : 0;
  endtask

  task automatic cycle(input bit stall, input bit redir, input logic [31:0] rpc);
    i_stall = stall;
    i_redirect = redir;
    i_redirect_pc = rpc;
    slave_drive();
    #1;
    monitor();
    @(negedge clk);
    slave_update();
  endtask

  task automatic do_reset(input int em);
    rst = 1'b1;
    i_stall = 0; i_redirect = 0; i_redirect_pc = 0;
    i_arready = 0; i_rvalid = 0; i_rlast = 0; i_rid = 0; i_rdata = 0; i_rresp = 0;
    err_mode = em; ar_wait = 0; r_wait = 0; rand_lat = 0;
    pend = 0; r_cnt = 0; ar_cnt = 0; hs_ar = 0; hs_r = 0; prev_ar_stall = 0; prev_araddr = 0;
    ar_log.delete(); pc_log.delete(); inst_log.delete();
    exp_pc = 32'h0; pops = 0; redirs = 0; cyc = 0; first_valid = -1;
    #1;
    check("rst_ctrl", {29'b0, o_valid_inst, o_arvalid, o_rready}, 32'd0);
    check("rst_araddr", o_araddr, 32'd0);
    check("rst_pc", o_pc, 32'd0);
    check("rst_inst", o_inst, 32'd0);
    check("rst_fetch_cnt", o_fetch_cnt, 32'd0);
    check("rst_flush_cnt", o_flush_cnt, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n0, p0;
    logic [31:0] r;
    tbl[0] = '{0, 0, 32'h0, mem_word(32'h0)};
    tbl[1] = '{0, 1, 32'h4, mem_word(32'h4)};
    tbl[2] = '{0, 2, 32'h8, mem_word(32'h8)};
    tbl[3] = '{1, 0, 32'h0, mem_word(32'h0)};
    tbl[4] = '{1, 1, 32'h4, mem_word(32'h4)};
    tbl[5] = '{1, 2, 32'h8, NOP_INST};
    tbl[6] = '{1, 3, 32'hC, mem_word(32'hC)};

    // in-order fetch, latency, and error beat replaced by NOP
    for (int em = 0; em < 2; em++) begin
      do_reset(em);
      for (int k = 0; k < 12; k++) cycle(0, 0, 0);
      check("first_valid_cycle", first_valid, 32'd3);
      check("steady_pops", pops, 32'd5);
      foreach (tbl[i]) if (tbl[i].em == em) begin
        check("tbl_araddr", qget(ar_log, tbl[i].idx), tbl[i].pc);
        check("tbl_pc", qget(pc_log, tbl[i].idx), tbl[i].pc);
        check("tbl_inst", qget(inst_log, tbl[i].idx), tbl[i].inst);
      end
    end

    // stall fills the buffer and blocks further requests
    do_reset(0);
    for (int k = 0; k < 10; k++) cycle(1, 0, 0);
    check("stall_reads", ar_log.size(), 32'd2);
    check("stall_arvalid", 32'(o_arvalid), 32'd0);
    check("stall_valid", 32'(o_valid_inst), 32'd1);
    for (int k = 0; k < 20; k++) cycle(0, 0, 0);
    check("stall_after_pc2", qget(pc_log, 2), 32'h8);
    check("stall_after_cnt", 32'(pc_log.size() >= 6), 32'd1);

    // redirect while in R: with the beat in the same cycle, and with the beat arriving later
    for (int rw = 0; rw < 3; rw += 2) begin
      do_reset(0);
      r_wait = rw;
      for (int k = 0; k < 50 && !o_rready; k++) cycle(0, 0, 0);
      check("reach_r", 32'(o_rready), 32'd1);
      n0 = ar_log.size();
      p0 = pc_log.size();
      cycle(0, 1, 32'h100);
      for (int k = 0; k < 20; k++) cycle(0, 0, 0);
      check("r_redir_araddr", qget(ar_log, n0), 32'h100);
      check("r_redir_pc", qget(pc_log, p0), 32'h100);
    end

    // redirect while AR is stalled: request held, beat dropped, refetch at aligned target
    do_reset(0);
    ar_wait = 5;
    for (int k = 0; k < 50 && !o_arvalid; k++) cycle(0, 0, 0);
    check("reach_ar", 32'(o_arvalid), 32'd1);
    n0 = ar_log.size();
    p0 = pc_log.size();
    cycle(0, 1, 32'h203);
    for (int k = 0; k < 40; k++) cycle(0, 0, 0);
    check("ar_redir_held", qget(ar_log, n0), 32'h0);
    check("ar_redir_next", qget(ar_log, n0 + 1), 32'h200);
    check("ar_redir_pc", qget(pc_log, p0), 32'h200);

    // perf counters: 5 pops then 2 redirects
    do_reset(0);
    for (int k = 0; k < 60 && pops < 5; k++) cycle(0, 0, 0);
    cycle(1, 1, 32'h40);
    cycle(1, 1, 32'h80);
    cycle(1, 0, 0);
    check("cnt_model_pops", pops, 32'd5);
`ifdef IFU_PERF_CNT_EN
    check("fetch_cnt", o_fetch_cnt, 32'd5);
    check("flush_cnt", o_flush_cnt, 32'd2);
`else
    check("fetch_cnt_off", o_fetch_cnt, 32'd0);
    check("flush_cnt_off", o_flush_cnt, 32'd0);
`endif

    // randomized traffic against the stream model
    do_reset(2);
    rand_lat = 1;
    ar_wait = $urandom_range(0, 3);
    for (int k = 0; k < 3000; k++) begin
      r = $urandom;
      cycle($urandom_range(0, 9) < 3, $urandom_range(0, 39) == 0,
            r[31:29] == 3'd0 ? {28'hFFFF_FFF, r[3:0]} : {20'h0, r[11:0]});
    end
    check("random_progress", 32'(pops > 100), 32'd1);
`ifdef IFU_PERF_CNT_EN
    check("rand_fetch_cnt", o_fetch_cnt, pops);
    check("rand_flush_cnt", o_flush_cnt, redirs);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
